// File: rtl/fuzz_sig_pipe.sv
// fuzz_sig_pipe: STAGES-deep ALU pipeline with valid/ready handshake and a running output signature.
module fuzz_sig_pipe #(
  parameter int DW     = 16,
  parameter int STAGES = 3,
  parameter int SIGW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  input  logic [1:0]      mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  input  logic            sig_clear,
  output logic [SIGW-1:0] sig,
  output logic [15:0]     count,
  output logic [1:0]      state
);
  localparam int SW = $clog2(DW);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;
  logic [STAGES-1:0] r_v;
  logic [DW-1:0]     r_d [STAGES];
  state_t            r_state;
  logic [SIGW-1:0]   r_sig;
  logic [15:0]       r_count;
  logic [2*DW-1:0]   w_dbl;
  logic [DW-1:0]     w_res;
  logic [STAGES-1:0] w_nv;
  logic [SIGW-1:0]   w_ext;
  logic              w_hs;
  // rotate via a doubled copy so a zero shift amount needs no special case
  assign w_dbl     = {in_a, in_a} << in_b[SW-1:0];
  assign w_res     = mode == 2'd0 ? in_a ^ in_b :
                     mode == 2'd1 ? in_a + in_b :
                     mode == 2'd2 ? in_a - in_b : w_dbl[2*DW-1:DW];
  assign out_valid = r_v[STAGES-1];
  assign out_data  = r_d[STAGES-1];
  assign in_ready  = !out_valid || out_ready;
  assign w_hs      = out_valid && out_ready;
  assign w_nv      = in_ready ? (r_v << 1) | STAGES'(in_valid) : r_v;
  assign w_ext     = SIGW'(out_data);
  assign sig       = r_sig;
  assign count     = r_count;
  assign state     = r_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v     <= '0;
      for (int i = 0; i < STAGES; i++) r_d[i] <= '0;
      r_state <= IDLE;
      r_sig   <= '0;
      r_count <= '0;
    end else begin
      r_v <= w_nv;
      if (in_ready) begin
        r_d[0] <= in_valid ? w_res : '0;
        for (int i = 1; i < STAGES; i++) r_d[i] <= r_d[i-1];
      end
      r_state <= ~|w_nv ? IDLE : (out_valid && !out_ready) ? HOLD : BUSY;
      if (sig_clear) begin
        r_sig   <= w_hs ? w_ext : '0;
        r_count <= w_hs ? 16'd1 : 16'd0;
      end else if (w_hs) begin
        r_sig   <= {r_sig[SIGW-2:0], r_sig[SIGW-1]} ^ w_ext;
        r_count <= r_count + 16'(r_count != 16'hFFFF);
      end
    end
  end
endmodule

// File: doc/fuzz_sig_pipe.md
FUZZ_SIG_PIPE -- requirements
Module: fuzz_sig_pipe

Interface
REQ-001 SHALL have parameter DW, default 16: data width, one of 8/16/32/64.
REQ-002 SHALL have parameter STAGES, default 3: pipeline depth, 1..8.
REQ-003 SHALL have parameter SIGW, default 32: signature width, SIGW >= DW.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_a  input  DW  operand A.
REQ-009 SHALL have port in_b  input  DW  operand B.
REQ-010 SHALL have port mode  input  2  operation select, sampled with the beat.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-013 SHALL have port out_data  output  DW  result.
REQ-014 SHALL have port sig_clear  input  1  clear signature and count.
REQ-015 SHALL have port sig  output  SIGW  running output signature.
REQ-016 SHALL have port count  output  16  number of consumed results, saturating.
REQ-017 SHALL have port state  output  2  occupancy state: 0 IDLE, 1 BUSY, 2 HOLD.

Function
REQ-018 SHALL compute the result from the operands using mode: 0 a^b; 1 a+b mod 2^DW; 2 a-b mod 2^DW (two's complement); 3 rotate a left by b[log2(DW)-1:0].
REQ-019 SHALL be a STAGES-deep register pipeline with one valid bit per stage; the result appears on out_data STAGES cycles after acceptance when there is no stall.
REQ-020 SHALL drive in_ready = !out_valid || out_ready as a combinational function of these signals; the whole pipeline advances only when in_ready = 1.
REQ-021 SHALL hold all stages, out_data and out_valid unchanged while in_ready = 0.
REQ-022 SHALL load a bubble (valid 0) into stage 0 on an advance cycle with in_valid = 0.
REQ-023 SHALL deliver results in acceptance order with no loss or duplication; back-to-back throughput SHALL be one beat per cycle.
REQ-024 SHALL update the signature on each output handshake: sig <= rotl1(sig) ^ zero-extend(out_data).
REQ-025 SHALL update the count on each output handshake: count <= count+1, saturating at 0xFFFF.
REQ-026 SHALL clear on sig_clear alone: sig <= 0, count <= 0.
REQ-027 SHALL treat sig_clear coincident with a handshake as: sig <= zero-extend(out_data), count <= 1.
REQ-028 SHALL register state, reflecting post-edge occupancy: IDLE when no stage is valid; HOLD when out_valid=1 and out_ready was 0 that cycle; otherwise BUSY.
REQ-029 SHALL take these state transitions: IDLE->BUSY on acceptance; BUSY->HOLD when the output stalls; HOLD->BUSY on release; BUSY->IDLE when the last valid beat drains.
REQ-030 SHALL keep out_data equal to the last computed stage value, including bubbles, so that it is deterministic for differential simulation.

Reset
REQ-031 SHALL clear, when rst = 1 at a clock edge, all stage valid bits, stage data, out_data, sig, count and state to 0 (IDLE).
REQ-032 SHALL have rst override every input, including sig_clear, handshakes and beats in flight; in-flight beats SHALL be discarded.
REQ-033 SHALL drive in_ready = 1 during and immediately after reset, since out_valid = 0.

Verification (DW=16, STAGES=3, SIGW=32)
REQ-034 SHALL cover: mode0 a=0x1234 b=0x00FF, out_ready=1 -> out_valid 3 cycles later, out_data=0x12CB.
REQ-035 SHALL cover: mode1 a=0xFFFF b=0x0002 -> 0x0001; mode2 a=0x0003 b=0x0005 -> 0xFFFE; mode3 a=0x8001 b=0x0004 -> 0x0018; all three fed back-to-back and emitted on consecutive cycles.
REQ-036 SHALL cover: 3 beats in flight with out_ready=0 -> in_ready=0, out_data held, state=HOLD; then out_ready=1 -> beats drain in order, state BUSY then IDLE.
REQ-037 SHALL cover: sig_clear, then consume results 0x0001 and 0x0002 -> sig=0x00000001 then 0x00000000, count=2.
REQ-038 SHALL cover: sig_clear coincident with a handshake of 0x00AB -> sig=0x000000AB, count=1.
REQ-039 SHALL cover: rst asserted with 2 beats in flight -> next cycle out_valid=0, sig=0, count=0, state=IDLE, and no stale beat emitted afterwards.
